// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, powers of ten and sequencer states for uart_num_tx.
package uart_pkg;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [16:0] POW10 [5] = '{17'd1, 17'd10, 17'd100, 17'd1000, 17'd10000};
  localparam int UART_DIV = 868;
  typedef enum logic [2:0] {IDLE, CONV, SEND, HOLD, WAIT, FIN} state_t;
endpackage

// File: rtl/bin2dec_seq.sv
// bin2dec_seq: repeated-subtraction binary to BCD converter, one step per cycle.
module bin2dec_seq
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        go,
  input  logic [15:0] value,
  output logic [3:0]  d4,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic        valid
);
  logic        run_q, run_d, valid_q, valid_d;
  logic [2:0]  k_q, k_d;
  logic [16:0] rem_q, rem_d;
  logic [3:0]  d_q [5];
  logic [3:0]  d_d [5];
  // At k = 1 the remainder is below 10, so it is the units digit directly.
  always_comb begin
    run_d = run_q;
    k_d = k_q;
    rem_d = rem_q;
    d_d = d_q;
    valid_d = 1'b0;
    if (go) begin
      run_d = 1'b1;
      k_d = 3'd4;
      rem_d = {1'b0, value};
      d_d = '{default: 4'd0};
    end else if (run_q) begin
      if (rem_q >= POW10[k_q]) begin
        rem_d = rem_q - POW10[k_q];
        d_d[k_q] = d_q[k_q] + 4'd1;
      end else if (k_q == 3'd1) begin
        d_d[0] = rem_q[3:0];
        valid_d = 1'b1;
        run_d = 1'b0;
      end else k_d = k_q - 3'd1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
      valid_q <= 1'b0;
      k_q <= 3'd0;
      rem_q <= '0;
      d_q <= '{default: 4'd0};
    end else begin
      run_q <= run_d;
      valid_q <= valid_d;
      k_q <= k_d;
      rem_q <= rem_d;
      d_q <= d_d;
    end
  end
  assign {d4, d3, d2, d1, d0} = {d_q[4], d_q[3], d_q[2], d_q[1], d_q[0]};
  assign valid = valid_q;
endmodule

// File: rtl/uart_num_tx.sv
// uart_num_tx: sends a 16-bit value as decimal ASCII (optionally + CR LF)
// through the uart write port, one byte per tx_busy handshake.
module uart_num_tx
  import uart_pkg::*;
#(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit SEND_CRLF = 1'b1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  output logic        busy,
  output logic        done
);
  state_t      state_q, state_d;
  logic [2:0]  pos_q, pos_d, first_idx, next_pos;
  logic [3:0]  gcnt_q, gcnt_d, d4, d3, d2, d1, d0, dsel;
  logic [7:0]  tx_data_q, tx_data_d, byte_out;
  logic        tx_we_q, tx_we_d, go, conv_valid, last, fire;
  assign go = state_q == IDLE && start;
  bin2dec_seq u_conv (
    .clk(clk), .rstn(rstn), .go(go), .value(value),
    .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .valid(conv_valid)
  );
  // Byte pointer: 4..0 select digits, 7 is CR, 6 is LF.
  assign first_idx = !SUPPRESS_ZEROS ? 3'd4 : d4 != 0 ? 3'd4 : d3 != 0 ? 3'd3 :
                     d2 != 0 ? 3'd2 : d1 != 0 ? 3'd1 : 3'd0;
  assign dsel = pos_q == 3'd4 ? d4 : pos_q == 3'd3 ? d3 : pos_q == 3'd2 ? d2 :
                pos_q == 3'd1 ? d1 : d0;
  assign byte_out = pos_q == 3'd7 ? ASCII_CR : pos_q == 3'd6 ? ASCII_LF : ASCII_0 + {4'd0, dsel};
  assign last = pos_q == 3'd6 || (pos_q == 3'd0 && !SEND_CRLF);
  assign next_pos = pos_q == 3'd0 ? 3'd7 : pos_q == 3'd7 ? 3'd6 : pos_q - 3'd1;
  assign fire = state_q == SEND && !tx_busy;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = start ? CONV : IDLE;
      CONV: state_d = conv_valid ? SEND : CONV;
      SEND: state_d = !tx_busy ? HOLD : SEND;
      HOLD: state_d = gcnt_q == 4'd1 ? WAIT : HOLD;
      WAIT: state_d = tx_busy ? WAIT : last ? FIN : SEND;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pos_d = state_q == CONV && conv_valid ? first_idx :
            state_q == WAIT && !tx_busy && !last ? next_pos : pos_q;
    tx_we_d = fire;
    tx_data_d = fire ? byte_out : tx_data_q;
    gcnt_d = fire ? 4'(GUARD_CYCLES) : state_q == HOLD ? gcnt_q - 4'd1 : gcnt_q;
    busy = state_q != IDLE;
    done = state_q == FIN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_q <= 3'd0;
      gcnt_q <= 4'd0;
      tx_data_q <= 8'h00;
      tx_we_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      gcnt_q <= gcnt_d;
      tx_data_q <= tx_data_d;
      tx_we_q <= tx_we_d;
    end
  end
  assign tx_data = tx_data_q;
  assign tx_we = tx_we_q;
endmodule

// File: tb/tb_uart_num_tx.sv
// tb_uart_num_tx: scoreboard bench with a behavioural uart (busy model, serial line
// and receiver) for uart_num_tx.
module tb_uart_num_tx;
  import uart_pkg::*;
  logic clk = 0, rstn = 0, start_a = 0, start_b = 0, hold_busy = 0, rx_en = 0;
  logic [15:0] value = 0;
  logic [7:0] tx_data_a, tx_data_b;
  logic tx_we_a, busy_a, done_a, tx_we_b, busy_b, done_b, tx_busy_a, line;
  int checks = 0, errors = 0, div = 1, ncyc = 0, last_fall = -10, we_cnt = 0, dcnt = 0, bcnt = 0;
  logic [7:0] exp_q[$], exp_b[$], rx_q[$];
  logic active = 0, prev_busy = 0;
  logic [9:0] sh = '1;

  always #5 clk = ~clk;
  assign tx_busy_a = active | hold_busy;
  assign line = active ? sh[0] : 1'b1;

  uart_num_tx dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .value(value), .tx_busy(tx_busy_a),
    .tx_data(tx_data_a), .tx_we(tx_we_a), .busy(busy_a), .done(done_a)
  );
  uart_num_tx #(.SUPPRESS_ZEROS(1'b0), .SEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .value(value), .tx_busy(1'b0),
    .tx_data(tx_data_b), .tx_we(tx_we_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Uart transmitter model: busy rises the cycle after tx_we, 10 bit times of div cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= 1'b0;
      sh <= '1;
      dcnt <= 0;
      bcnt <= 0;
    end else if (!active) begin
      if (tx_we_a) begin
        sh <= {1'b1, tx_data_a, 1'b0};
        active <= 1'b1;
        dcnt <= 0;
        bcnt <= 0;
      end
    end else if (dcnt == div - 1) begin
      dcnt <= 0;
      sh <= {1'b1, sh[9:1]};
      bcnt <= bcnt + 1;
      if (bcnt == 9) active <= 1'b0;
    end else dcnt <= dcnt + 1;
  end

  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (rx_en && !line) begin
      repeat (div / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        b[i] = line;
      end
      repeat (div) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    prev_busy <= tx_busy_a;
    if (prev_busy && !tx_busy_a) last_fall <= ncyc;
    if (tx_we_a) begin
      we_cnt <= we_cnt + 1;
      chk("we_while_busy", tx_busy_a, 0);
      if (exp_q.size() == 0) chk("extra_byte_a", 1, 0);
      else chk("byte_a", tx_data_a, exp_q.pop_front());
    end
    if (done_a) chk("done_after_busy_fall", ncyc, last_fall + 1);
  end

  always @(negedge clk) begin
    if (tx_we_b) begin
      if (exp_b.size() == 0) chk("extra_byte_b", 1, 0);
      else chk("byte_b", tx_data_b, exp_b.pop_front());
    end
  end

  task automatic kick_a(input logic [15:0] v, output int n);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    n = s.len() + 2;
    value = v;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
  endtask

  task automatic end_a(input int w0, input int n, input bit coinc);
    int i = 0;
    int limit = n * (10 * div + 10) + 200;
    while (!done_a && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("done_a", done_a, 1);
    if (coinc) begin
      value = 16'd5;
      start_a = 1;
      @(negedge clk);
      start_a = 0;
      chk("coinc_busy", busy_a, 0);
      repeat (20) @(negedge clk);
    end else @(negedge clk);
    chk("pulses_a", we_cnt - w0, n);
    chk("queue_empty_a", exp_q.size(), 0);
  endtask

  task automatic run_a(input logic [15:0] v);
    int w0, n;
    w0 = we_cnt;
    kick_a(v, n);
    end_a(w0, n, 1'b0);
  endtask

  task automatic run_b(input logic [15:0] v);
    string s;
    int i = 0;
    s = $sformatf("%05d", v);
    for (int j = 0; j < s.len(); j++) exp_b.push_back(s[j]);
    value = v;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    while (!done_b && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("done_b", done_b, 1);
    @(negedge clk);
    chk("queue_empty_b", exp_b.size(), 0);
  endtask

  task automatic loop_a(input logic [15:0] v);
    string s;
    logic [7:0] e;
    int n;
    s = $sformatf("%0d", v);
    n = s.len() + 2;
    rx_q.delete();
    rx_en = 1;
    run_a(v);
    rx_en = 0;
    chk("rx_len", rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      e = i < s.len() ? s[i] : i == s.len() ? 8'h0D : 8'h0A;
      chk("rx_byte", rx_q[i], e);
    end
  endtask

  initial begin
    int w0, n, lat, cnt;
    repeat (3) @(negedge clk);
    chk("rst_tx_we", tx_we_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tx_data", tx_data_a, 8'h00);
    chk("rst_busy_b", busy_b, 0);
    rstn = 1;
    @(negedge clk);
    w0 = we_cnt;
    kick_a(16'd1234, n);
    end_a(w0, n, 1'b1);
    run_a(16'd0);
    run_b(16'd0);
    run_b(16'd1234);
    w0 = we_cnt;
    kick_a(16'd65535, n);
    lat = 0;
    while (!tx_we_a && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("first_we_latency_ok", lat <= 26, 1);
    end_a(w0, n, 1'b0);
    hold_busy = 1;
    w0 = we_cnt;
    kick_a(16'd42, n);
    repeat (50) @(negedge clk);
    value = 16'd99;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (50) @(negedge clk);
    chk("stuck_no_we", we_cnt - w0, 0);
    hold_busy = 0;
    repeat (6) @(negedge clk);
    chk("release_one_pulse", we_cnt - w0, 1);
    end_a(w0, n, 1'b0);
    w0 = we_cnt;
    kick_a(16'd4321, n);
    cnt = 0;
    lat = 0;
    while (cnt < 3 && lat < 500) begin
      @(negedge clk);
      lat++;
      if (tx_we_a) cnt++;
    end
    chk("third_byte_seen", cnt, 3);
    #1 rstn = 0;
    #1;
    chk("async_rst_tx_we", tx_we_a, 0);
    chk("async_rst_busy", busy_a, 0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    run_a(16'd7);
    run_a(16'd999);
    run_a(16'd1000);
    div = UART_DIV;
    loop_a(16'd9);
    loop_a(16'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
